// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and types for the PS/2 mouse packet path
package ps2_pkg;

  typedef logic [1:0] state_t;

  localparam state_t B1   = 2'd0;
  localparam state_t B2   = 2'd1;
  localparam state_t B3   = 2'd2;
  localparam state_t DONE = 2'd3;

  localparam int PS2_PKT_BYTES = 3;

  localparam int BTN_LSB  = 0;
  localparam int SYNC_BIT = 3;
  localparam int XS_BIT   = 4;
  localparam int YS_BIT   = 5;
  localparam int XOV_BIT  = 6;
  localparam int YOV_BIT  = 7;

  // Byte1 minus its always-one sync bit, which carries no information once accepted.
  typedef struct packed {
    logic       yov;
    logic       xov;
    logic       ys;
    logic       xs;
    logic [2:0] btn;
  } byte1_t;

endpackage

// File: rtl/ps2_timeout_cnt.sv
// rtl/ps2_timeout_cnt.sv - clear/enable counter that saturates at LIMIT-1 and flags it
module ps2_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] TC_VAL = W'(LIMIT - 1);

  logic [W-1:0] count_q;

  assign tc = (count_q == TC_VAL);

  // Holding at the terminal value keeps the counter from ever wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && !tc) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_mouse_pkt.sv
// rtl/ps2_mouse_pkt.sv - assembles PS/2 receiver bytes into 3-byte mouse packets
module ps2_mouse_pkt
  import ps2_pkg::*;
#(
  parameter int TIMEOUT = 1_250_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  output logic [2:0] btn,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic       xov,
  output logic       yov,
  output logic       m_done_tick,
  output logic       sync_err
);

  state_t     state_q;
  state_t     state_d;
  byte1_t     byte1_q;
  logic [7:0] byte2_q;
  logic       sync_err_q;

  logic in_pkt;
  logic tmo_tc;
  logic accept_b1;
  logic reject_b1;
  logic accept_b2;
  logic accept_b3;
  logic timeout;

  ps2_timeout_cnt #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk  (clk),
    .reset(reset),
    .clr  (!in_pkt || rx_done_tick),
    .en   (in_pkt),
    .tc   (tmo_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= B1;
    end else begin
      state_q <= state_d;
    end
  end

  // DONE behaves like B1 for the incoming byte so back-to-back packets lose nothing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      B1, DONE: begin
        if (en && rx_done_tick && rx_data[SYNC_BIT]) begin
          state_d = B2;
        end else begin
          state_d = B1;
        end
      end
      B2: begin
        if (rx_done_tick) begin
          state_d = B3;
        end else if (tmo_tc) begin
          state_d = B1;
        end
      end
      B3: begin
        if (rx_done_tick) begin
          state_d = DONE;
        end else if (tmo_tc) begin
          state_d = B1;
        end
      end
      default: state_d = B1;
    endcase
  end

  always_comb begin
    rx_en       = 1'b0;
    m_done_tick = 1'b0;
    in_pkt      = 1'b0;
    accept_b1   = 1'b0;
    reject_b1   = 1'b0;
    accept_b2   = 1'b0;
    accept_b3   = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      B1, DONE: begin
        rx_en       = en;
        m_done_tick = (state_q == DONE);
        accept_b1   = en && rx_done_tick && rx_data[SYNC_BIT];
        reject_b1   = en && rx_done_tick && !rx_data[SYNC_BIT];
      end
      B2: begin
        rx_en     = 1'b1;
        in_pkt    = 1'b1;
        accept_b2 = rx_done_tick;
        timeout   = !rx_done_tick && tmo_tc;
      end
      B3: begin
        rx_en     = 1'b1;
        in_pkt    = 1'b1;
        accept_b3 = rx_done_tick;
        timeout   = !rx_done_tick && tmo_tc;
      end
      default: begin
        rx_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte1_q    <= '0;
      byte2_q    <= '0;
      btn        <= '0;
      xm         <= '0;
      ym         <= '0;
      xov        <= 1'b0;
      yov        <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= reject_b1 || timeout;
      if (accept_b1) begin
        byte1_q.btn <= rx_data[BTN_LSB +: 3];
        byte1_q.xs  <= rx_data[XS_BIT];
        byte1_q.ys  <= rx_data[YS_BIT];
        byte1_q.xov <= rx_data[XOV_BIT];
        byte1_q.yov <= rx_data[YOV_BIT];
      end
      if (accept_b2) begin
        byte2_q <= rx_data;
      end
      // Byte3 goes straight to the outputs on the edge that samples it.
      if (accept_b3) begin
        btn <= byte1_q.btn;
        xm  <= {byte1_q.xs, byte2_q};
        ym  <= {byte1_q.ys, rx_data};
        xov <= byte1_q.xov;
        yov <= byte1_q.yov;
      end
    end
  end

  assign sync_err = sync_err_q;

endmodule

// File: doc/ps2_mouse_pkt.md
# ps2_mouse_pkt

Assembles the byte stream from the PS/2 receiver into standard 3-byte mouse movement packets. It sits directly downstream of the PS/2 receive stage: it consumes that stage's `rx_done_tick` / `dout` byte strobe and drives its `rx_en`. For each complete packet it presents the decoded buttons, signed 9-bit X/Y deltas and overflow flags with a one-cycle done strobe. It resynchronises on framing errors and on stalled packets.

## Interface
- `TIMEOUT`, default 1_250_000: max clk cycles allowed between bytes of one packet (25 ms at 50 MHz); must be ≥ 2.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  stream enable; when low, no new packet is started.
- `rx_done_tick`  in  1  one-cycle strobe, byte valid on `rx_data`.
- `rx_data`  in  8  received byte (receiver `dout`).
- `rx_en`  out  1  receive enable to the receiver.
- `btn`  out  3  {middle, right, left} = byte1[2:0].
- `xm`  out  9  X delta, two's complement {byte1[4], byte2}.
- `ym`  out  9  Y delta, two's complement {byte1[5], byte3}.
- `xov`, `yov`  out  1 each  byte1[6], byte1[7].
- `m_done_tick`  out  1  one-cycle strobe, packet outputs updated.
- `sync_err`  out  1  one-cycle strobe, byte1 rejected or packet timed out.

## Operation
- States: `B1` (await byte1), `B2`, `B3`, `DONE`. Reset → `B1`.
- `rx_en` = `en` in `B1` and `DONE`; forced 1 in `B2` and `B3` so that a started packet always completes.
- `B1`/`DONE` + `rx_done_tick`:
  - If `rx_data[3]` == 1, latch byte1 into an internal register → `B2`.
  - If `rx_data[3]` == 0, drop the byte, pulse `sync_err`, → `B1`.
- `B2` + tick: latch byte2 → `B3`.
- `B3` + tick: on the same edge, load `btn`, `xm`, `ym`, `xov`, `yov` from byte1, byte2 and the current `rx_data`; → `DONE`.
- `DONE`: `m_done_tick` = 1 for exactly this cycle. Without a tick → `B1`. With a tick → handled as `B1` (no byte lost).
- Timeout counter:
  - Cleared on every accepted byte and in `B1`/`DONE`.
  - Increments each cycle in `B2`/`B3`.
  - When it reaches `TIMEOUT`-1 with no tick that cycle: → `B1`, pulse `sync_err`, discard the partial packet.
  - A tick in that same cycle wins; the byte is accepted.
- Counter width is `$clog2(TIMEOUT)`; the counter never wraps.
- Packet outputs hold their value until the next completed packet. The internal byte1/byte2 registers are never visible externally.
- `en` falling mid-packet has no effect; the packet completes or times out.
- The value of `rx_data` is don't-care when `rx_done_tick` is 0.

## Timing
- Reset values: all outputs 0, except `rx_en` = `en` (combinational from the state).
- `m_done_tick` is asserted in the cycle after the clk edge that samples byte3. Output data is valid in that same cycle.
- `sync_err` is registered, so it is asserted in the cycle after the offending edge.
- Back-to-back ticks on consecutive cycles are supported at full rate.
- Asynchronous reset mid-packet: immediate return to `B1`, outputs cleared, partial packet discarded.

## Structure
- Shared package `ps2_pkg`:
  - state encoding localparams `B1`/`B2`/`B3`/`DONE` (2-bit);
  - `PS2_PKT_BYTES` = 3;
  - byte1 bit-position constants (`BTN_LSB`, `SYNC_BIT`=3, `XS_BIT`=4, `YS_BIT`=5, `XOV_BIT`=6, `YOV_BIT`=7).
- One natural sub-module: `ps2_timeout_cnt`, a parameterised clear/enable counter with a terminal-count output.
- The top level `ps2_mouse` instantiates the receive stage and this block.

## Test plan
- Basic packet:
  - Stimulus: `en`=1; ticks with 0x09, 0x05, 0x10.
  - Required: `btn`=001, `xm`=0x005, `ym`=0x010, ovf flags 0, one `m_done_tick`.
- Negative Y and overflow:
  - Stimulus: bytes 0xE8, 0xFF, 0xFB (sign bit on Y, both overflow flags set).
  - Required: `xm`=0x0FF, `ym`=0x1FB (−5), `xov`=`yov`=1, `btn`=000.
- Bad sync bit:
  - Stimulus: 0x01, then 0x08, 0x01, 0x02.
  - Required: one `sync_err` pulse after 0x01; the following packet decodes `xm`=0x001, `ym`=0x002.
- Timeout:
  - Stimulus: `TIMEOUT`=16; bytes 0x08, 0x03, then 20 idle cycles; then a full packet 0x08, 0x04, 0x06.
  - Required: `sync_err` pulse, no `m_done_tick` for the partial packet; the full packet decodes `xm`=0x004, `ym`=0x006.
- Back-to-back packets:
  - Stimulus: 6 ticks on consecutive cycles, with the first byte of packet 2 arriving in the `DONE` cycle.
  - Required: two `m_done_tick` pulses 3 cycles apart, both packets correct.
- Reset and enable:
  - Stimulus: reset asserted after byte2; then `en`=0.
  - Required: outputs 0, state `B1`; with `en`=0, `rx_en`=0 and no packet starts.
